gf_digit_pe: RTL and testbench
==============================

// Module: gf_digit_pe
// PURPOSE
//  Parametrised GF(2^M) systolic processing element, successor to the fixed 8-bit bit-serial cell.
//  Consumes multiplier A as D-bit digits, MSB-first, one digit per accepted beat, against a
//  latched multiplicand B and modulus G. After M/D digits it emits P = A*B mod G.
//  A/B/G/ctr/valid are forwarded one cycle later so cells chain into a systolic row.
// PARAMETERS
//  M  8  field degree; the operand and result width. Legal range 2..32.
//  D  1  digit width, in bits per beat. Must satisfy 1<=D<=M and M%D==0.
//  N = M/D is derived and is not overridable. It is the number of beats per operation.
// PORTS
//  clk      in   1  rising-edge clock
//  rst      in   1  asynchronous, active-low reset
//  ctr_i    in   1  first-digit marker; meaningful only when a_vld_i=1
//  a_vld_i  in   1  digit valid; a low value is a bubble
//  a_i      in   D  multiplier digit; a_i[D-1] is the highest-order bit
//  b_i      in   M  multiplicand; sampled on a first beat
//  g_i      in   M  modulus low M bits (x^M implicit); sampled on a first beat
//  acc_i    in   M  addend XORed into the result. Present only with GF_PE_MAC_EN.
//  ctr_o    out  1  ctr_i delayed 1 cycle
//  a_vld_o  out  1  a_vld_i delayed 1 cycle
//  a_o      out  D  a_i delayed 1 cycle
//  b_o      out  M  b_i delayed 1 cycle
//  g_o      out  M  g_i delayed 1 cycle
//  p_o      out  M  last completed product; held until the next completion
//  p_vld_o  out  1  one-cycle pulse marking a new p_o
//  err_o    out  1  one-cycle pulse on a protocol error
// BEHAVIOUR
//  - Reset (rst=0, async): every output, b_q, g_q, p_acc and cnt clear to 0, and the state goes to IDLE.
//    Reset mid-operation discards the partial product and emits no p_vld_o.
//  - Forward path: the *_o copies are plain 1-cycle registers, independent of state and bubbles.
//  - step(p,a,b,g) = (p*x^D mod g) XOR sum_{j<D} a[j]*(b*x^j mod g). All arithmetic is carry-less, in M bits.
//  - States:
//    - IDLE: waiting for a first beat.
//    - ACC: cnt holds the number of digits consumed so far, in the range 1..N-1.
//  - Beat rules, applied only when a_vld_i=1:
//    - ctr_i=1 in IDLE: b_q<=b_i; g_q<=g_i; p_acc<=step(0,a_i,b_i,g_i); cnt<=1; go to ACC.
//      If N==1, complete immediately instead.
//    - ctr_i=1 in ACC: abort the current operation, pulse err_o, then restart exactly as the IDLE case above.
//    - ctr_i=0 in ACC: p_acc<=step(p_acc,a_i,b_q,g_q); cnt<=cnt+1.
//    - ctr_i=0 in IDLE: the digit is dropped, err_o pulses, and no state changes.
//  - Completion happens on the beat that consumes digit N.
//    - On the next cycle, p_o = final step value, optionally XOR acc_i sampled on that beat.
//    - On that same next cycle, p_vld_o=1. cnt then clears and the state returns to IDLE.
//  - Latency: p_vld_o asserts 1 cycle after the last accepted digit.
//    Without bubbles, a full operation takes N+1 cycles from the first beat.
//  - Bubbles (a_vld_i=0): p_acc, cnt and the state all hold. ctr_i is ignored.
//  - Back-to-back operations: a first beat may arrive in the cycle p_vld_o is high. There is no dead cycle.
//  - B and G changing mid-operation have no effect, because only the latched b_q and g_q are used.
// CONFIGURATION
//  GF_PE_MAC_EN defined: the acc_i port exists, and p_o = A*B mod G XOR acc_i.
//    This supports GF multiply-accumulate chains.
//  GF_PE_MAC_EN undefined: the acc_i port is absent, and p_o = A*B mod G.
// STRUCTURE
//  Package gf_pe_pkg:
//    - state enum {IDLE, ACC}
//    - function gf_mulx(v,g), which multiplies by x mod g
//    - a cnt width localparam derived via $clog2
//  Sub-module gf_digit_step: purely combinational step(). It is parametrised on M and D.
//  The top level holds the registers, the FSM and the forward path.
// TESTING
//  - M=8, D=1, g=0x1B, a=0x57, b=0x83, 8 beats
//    -> p_o=0xC1, with p_vld_o pulsing in cycle 9 after the first beat.
//  - M=8, D=2, same operands, 4 beats -> p_o=0xC1, with p_vld_o in cycle 5.
//  - D=1 case with a_vld_i low for 3 cycles after beat 4 -> p_o=0xC1, with p_vld_o 3 cycles later.
//    a_vld_o/a_o/ctr_o track the inputs exactly 1 cycle later.
//  - ctr_i=1 on beat 5 with a new operation a=0x02, b=0x87 (D=1)
//    -> err_o pulses once, the aborted result is never output, and p_o=0x15.
//  - rst low during beat 5, then a fresh a=0x57, b=0x83 operation
//    -> all outputs 0 during reset, no spurious p_vld_o, then p_o=0xC1.
//  - With GF_PE_MAC_EN: acc_i=0xFF on the final beat of 0x57*0x83 -> p_o=0x3E.
//    In the same build, an idle beat with a_vld_i=1 and ctr_i=0 -> a single err_o pulse and p_o unchanged.

Source files
------------

// File: rtl/gf_pe_pkg.sv
// -----------------------------------------------------------------------------
// gf_pe_pkg
// Shared types and helpers for the GF(2^M) digit-serial processing element.
//   state_e   : operation FSM state (IDLE / ACC)
//   GF_MAX_M  : largest supported field degree; helpers work at this width
//   CNT_W     : width of the digit counter (holds up to N-1 <= GF_MAX_M-1)
//   gf_mulx() : multiply a field element by x, reduced by the modulus
// -----------------------------------------------------------------------------
package gf_pe_pkg;

    localparam int GF_MAX_M = 32;
    localparam int CNT_W    = $clog2(GF_MAX_M);

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_e;

    // v * x mod (x^m + g). v and g are m-bit values zero-extended to
    // GF_MAX_M bits; the x^m term of the modulus is implicit.
    function automatic logic [GF_MAX_M-1:0] gf_mulx(
        input logic [GF_MAX_M-1:0] v,
        input logic [GF_MAX_M-1:0] g,
        input int unsigned         m
    );
        logic [GF_MAX_M-1:0] mask;
        logic [GF_MAX_M-1:0] r;
        logic [4:0]          top;
        if (m >= GF_MAX_M) begin
            mask = '1;
        end else begin
            mask = (GF_MAX_M'(1) << m) - GF_MAX_M'(1);
        end
        top = 5'(m - 1);
        r   = (v << 1) & mask;
        if (v[top]) begin
            r = r ^ g;
        end
        return r;
    endfunction

endpackage

// File: rtl/gf_digit_step.sv
// -----------------------------------------------------------------------------
// gf_digit_step
// Purely combinational digit step of the MSB-first GF(2^M) multiplier:
//   p_o = (p_i * x^D mod g) XOR sum_{j<D} a_i[j] * (b_i * x^j mod g)
// Parameters: M field degree, D digit width.
// Ports:
//   p_i  [M-1:0]  running partial product
//   a_i  [D-1:0]  multiplier digit, a_i[D-1] highest order
//   b_i  [M-1:0]  multiplicand
//   g_i  [M-1:0]  modulus low bits (x^M implicit)
//   p_o  [M-1:0]  updated partial product
// -----------------------------------------------------------------------------
module gf_digit_step
    import gf_pe_pkg::*;
#(
    parameter int M = 8,
    parameter int D = 1
) (
    input  logic [M-1:0] p_i,
    input  logic [D-1:0] a_i,
    input  logic [M-1:0] b_i,
    input  logic [M-1:0] g_i,
    output logic [M-1:0] p_o
);

    logic [M-1:0] p_sh  [D+1];
    logic [M-1:0] b_sh  [D];
    logic [M-1:0] sum_w [D+1];

    assign p_sh[0]  = p_i;
    assign b_sh[0]  = b_i;
    assign sum_w[0] = '0;

    // Bit j of the digit weights b*x^j; p is shifted D times in parallel.
    for (genvar j = 0; j < D; j++) begin : g_bit
        assign p_sh[j+1]  = M'(gf_mulx(GF_MAX_M'(p_sh[j]), GF_MAX_M'(g_i), M));
        assign sum_w[j+1] = a_i[j] ? (sum_w[j] ^ b_sh[j]) : sum_w[j];
        if (j < D - 1) begin : g_bnext
            assign b_sh[j+1] = M'(gf_mulx(GF_MAX_M'(b_sh[j]), GF_MAX_M'(g_i), M));
        end
    end

    assign p_o = p_sh[D] ^ sum_w[D];

endmodule

// File: rtl/gf_digit_pe.sv
// -----------------------------------------------------------------------------
// gf_digit_pe
// GF(2^M) systolic processing element. Consumes multiplier A as D-bit digits,
// MSB-first, against a multiplicand B and modulus G latched on the first beat;
// after N = M/D digits it emits P = A*B mod G. Inputs are forwarded one cycle
// later so cells chain into a systolic row.
// Optional feature macro: GF_PE_MAC_EN -- adds acc_i, XORed into the result
// (sampled on the final beat) for multiply-accumulate chains.
// Ports:
//   clk, rst (async, active-low)
//   ctr_i    first-digit marker (valid only with a_vld_i)
//   a_vld_i  digit valid; low = bubble
//   a_i      [D-1:0] multiplier digit
//   b_i, g_i [M-1:0] multiplicand / modulus, sampled on a first beat
//   acc_i    [M-1:0] addend (GF_PE_MAC_EN only)
//   ctr_o, a_vld_o, a_o, b_o, g_o   1-cycle delayed copies of the inputs
//   p_o      [M-1:0] last completed product, held until the next completion
//   p_vld_o  one-cycle pulse marking a new p_o
//   err_o    one-cycle pulse on a protocol error
// -----------------------------------------------------------------------------
module gf_digit_pe
    import gf_pe_pkg::*;
#(
    parameter int M = 8,
    parameter int D = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ctr_i,
    input  logic         a_vld_i,
    input  logic [D-1:0] a_i,
    input  logic [M-1:0] b_i,
    input  logic [M-1:0] g_i,
`ifdef GF_PE_MAC_EN
    input  logic [M-1:0] acc_i,
`endif
    output logic         ctr_o,
    output logic         a_vld_o,
    output logic [D-1:0] a_o,
    output logic [M-1:0] b_o,
    output logic [M-1:0] g_o,
    output logic [M-1:0] p_o,
    output logic         p_vld_o,
    output logic         err_o
);

    localparam int N = M / D;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [M-1:0]     b_q, g_q;
    logic [M-1:0]     pacc_q, pacc_d;
    logic [M-1:0]     p_q, p_d;
    logic             pvld_q, pvld_d;
    logic             err_q, err_d;

    logic             ctr_fwd_q, vld_fwd_q;
    logic [D-1:0]     a_fwd_q;
    logic [M-1:0]     b_fwd_q, g_fwd_q;

    logic             first_beat, cont_beat, done;
    logic [M-1:0]     step_p, step_b, step_g, step_out, acc_term;

    // A first beat restarts from a zero product with the freshly presented
    // B/G, so the step is fed from the inputs rather than the latches.
    assign first_beat = a_vld_i & ctr_i;
    assign cont_beat  = a_vld_i & ~ctr_i & (state_q == ACC);
    assign done       = first_beat ? (N == 1) : (cont_beat && (cnt_q == LAST_CNT));

    assign step_p = first_beat ? '0  : pacc_q;
    assign step_b = first_beat ? b_i : b_q;
    assign step_g = first_beat ? g_i : g_q;

`ifdef GF_PE_MAC_EN
    assign acc_term = acc_i;
`else
    assign acc_term = '0;
`endif

    gf_digit_step #(
        .M (M),
        .D (D)
    ) u_step (
        .p_i (step_p),
        .a_i (a_i),
        .b_i (step_b),
        .g_i (step_g),
        .p_o (step_out)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (first_beat && !done) state_d = ACC;
            end
            ACC: begin
                if (first_beat) begin
                    state_d = done ? IDLE : ACC;
                end else if (done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs / datapath next values
    always_comb begin
        cnt_d  = cnt_q;
        pacc_d = pacc_q;
        p_d    = p_q;
        pvld_d = done;
        // ctr_i=1 while busy aborts; ctr_i=0 while idle has nothing to join.
        err_d  = a_vld_i & (ctr_i ? (state_q == ACC) : (state_q == IDLE));
        if (first_beat || cont_beat) begin
            pacc_d = step_out;
            if (done) begin
                cnt_d = '0;
            end else if (first_beat) begin
                cnt_d = CNT_W'(1);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        if (done) begin
            p_d = step_out ^ acc_term;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            pacc_q <= '0;
            b_q    <= '0;
            g_q    <= '0;
            p_q    <= '0;
            pvld_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pacc_q <= pacc_d;
            p_q    <= p_d;
            pvld_q <= pvld_d;
            err_q  <= err_d;
            if (first_beat) begin
                b_q <= b_i;
                g_q <= g_i;
            end
        end
    end

    // Systolic forward path: unconditional one-cycle copies.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctr_fwd_q <= 1'b0;
            vld_fwd_q <= 1'b0;
            a_fwd_q   <= '0;
            b_fwd_q   <= '0;
            g_fwd_q   <= '0;
        end else begin
            ctr_fwd_q <= ctr_i;
            vld_fwd_q <= a_vld_i;
            a_fwd_q   <= a_i;
            b_fwd_q   <= b_i;
            g_fwd_q   <= g_i;
        end
    end

    assign ctr_o   = ctr_fwd_q;
    assign a_vld_o = vld_fwd_q;
    assign a_o     = a_fwd_q;
    assign b_o     = b_fwd_q;
    assign g_o     = g_fwd_q;
    assign p_o     = p_q;
    assign p_vld_o = pvld_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_gf_digit_pe.sv
// -----------------------------------------------------------------------------
// tb_gf_digit_pe
// Scoreboard bench for gf_digit_pe: one instance with M=8/D=1 and one with
// M=8/D=2. Build with GF_PE_MAC_EN to exercise the acc_i path.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_gf_digit_pe;

`ifdef GF_PE_MAC_EN
    localparam bit MAC = 1'b1;
`else
    localparam bit MAC = 1'b0;
`endif

    typedef struct {
        logic [7:0] p;
        int         due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // D=1 instance
    logic       ctr1, vld1;
    logic [0:0] a1;
    logic [7:0] b1, g1, acc1;
    logic       ctr1_o, vld1_o, pv1, err1;
    logic [0:0] a1_o;
    logic [7:0] b1_o, g1_o, p1;

    // D=2 instance
    logic       ctr2, vld2;
    logic [1:0] a2;
    logic [7:0] b2, g2, acc2;
    logic       ctr2_o, vld2_o, pv2, err2;
    logic [1:0] a2_o;
    logic [7:0] b2_o, g2_o, p2;

    gf_digit_pe #(.M(8), .D(1)) dut1 (
        .clk     (clk),
        .rst     (rst),
        .ctr_i   (ctr1),
        .a_vld_i (vld1),
        .a_i     (a1),
        .b_i     (b1),
        .g_i     (g1),
`ifdef GF_PE_MAC_EN
        .acc_i   (acc1),
`endif
        .ctr_o   (ctr1_o),
        .a_vld_o (vld1_o),
        .a_o     (a1_o),
        .b_o     (b1_o),
        .g_o     (g1_o),
        .p_o     (p1),
        .p_vld_o (pv1),
        .err_o   (err1)
    );

    gf_digit_pe #(.M(8), .D(2)) dut2 (
        .clk     (clk),
        .rst     (rst),
        .ctr_i   (ctr2),
        .a_vld_i (vld2),
        .a_i     (a2),
        .b_i     (b2),
        .g_i     (g2),
`ifdef GF_PE_MAC_EN
        .acc_i   (acc2),
`endif
        .ctr_o   (ctr2_o),
        .a_vld_o (vld2_o),
        .a_o     (a2_o),
        .b_o     (b2_o),
        .g_o     (g2_o),
        .p_o     (p2),
        .p_vld_o (pv2),
        .err_o   (err2)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int err_seen1 = 0, err_exp1 = 0, err_seen2 = 0;
    exp_t q1[$];
    exp_t q2[$];
    logic [7:0] last1 = 8'h00, last2 = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: full polynomial product, then reduction by x^8 + g.
    function automatic logic [7:0] gfmul(input logic [7:0] a, input logic [7:0] b, input logic [7:0] g);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (a[i]) p = p ^ (16'(b) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ ((16'(g) | 16'h0100) << (i - 8));
        return p[7:0];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    logic       pv_ctr, pv_vld, pv_rst;
    logic [0:0] pv_a;
    logic [7:0] pv_b, pv_g;
    always @(posedge clk) begin
        pv_ctr <= ctr1;
        pv_vld <= vld1;
        pv_a   <= a1;
        pv_b   <= b1;
        pv_g   <= g1;
        pv_rst <= rst;
    end

    // Monitor for the D=1 instance (also checks reset values of both).
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            check("rst_ctl1", {pv1, err1, ctr1_o, vld1_o, a1_o}, 0);
            check("rst_dat1", {b1_o, g1_o, p1}, 0);
            check("rst_ctl2", {pv2, err2, ctr2_o, vld2_o, a2_o}, 0);
            check("rst_dat2", {b2_o, g2_o, p2}, 0);
            last1 = 8'h00;
            last2 = 8'h00;
        end else begin
            if (pv_rst) begin
                check("fwd1_ctl", {ctr1_o, vld1_o, a1_o}, {pv_ctr, pv_vld, pv_a});
                check("fwd1_bg", {b1_o, g1_o}, {pv_b, pv_g});
            end
            if (err1) err_seen1++;
            if (pv1) begin
                if (q1.size() == 0) begin
                    check("p1_spurious_vld", 1, 0);
                end else begin
                    e = q1.pop_front();
                    check("p1_vld_cycle", cyc, e.due);
                    last1 = e.p;
                end
            end else if (q1.size() > 0 && cyc >= q1[0].due) begin
                check("p1_vld_missing", 0, 1);
                void'(q1.pop_front());
            end
            check("p1_value", p1, last1);
        end
    end

    // Monitor for the D=2 instance.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (err2) err_seen2++;
            if (pv2) begin
                if (q2.size() == 0) begin
                    check("p2_spurious_vld", 1, 0);
                end else begin
                    e = q2.pop_front();
                    check("p2_vld_cycle", cyc, e.due);
                    last2 = e.p;
                end
            end else if (q2.size() > 0 && cyc >= q2[0].due) begin
                check("p2_vld_missing", 0, 1);
                void'(q2.pop_front());
            end
            check("p2_value", p2, last2);
        end
    end

    task automatic bubble1(input int n);
        repeat (n) begin
            vld1 = 1'b0;
            ctr1 = 1'($urandom_range(0, 1));
            a1   = 1'($urandom_range(0, 1));
            b1   = 8'($urandom);
            g1   = 8'($urandom);
            @(posedge clk); #1;
        end
    endtask

    // Drives nbeats digits of a (MSB-first); a result is expected only when
    // all 8 digits are driven. Optional bubble run after digit bub_after.
    task automatic op1(input logic [7:0] a, input logic [7:0] b, input logic [7:0] g,
                       input logic [7:0] acc, input logic [7:0] prod,
                       input int nbeats, input int bub_after, input int bub_len);
        for (int k = 0; k < nbeats; k++) begin
            if (k == 0) begin
                b1 = b; g1 = g;
            end else begin
                b1 = 8'($urandom); g1 = 8'($urandom);
            end
            acc1 = (k == 7) ? acc : 8'($urandom);
            if (k == 7) q1.push_back('{p: prod ^ (MAC ? acc : 8'h00), due: cyc + 1});
            ctr1  = (k == 0);
            vld1  = 1'b1;
            a1[0] = a[3'(7 - k)];
            @(posedge clk); #1;
            if (k + 1 == bub_after) bubble1(bub_len);
        end
        vld1 = 1'b0;
        ctr1 = 1'b0;
    endtask

    task automatic op2(input logic [7:0] a, input logic [7:0] b, input logic [7:0] g,
                       input logic [7:0] acc, input logic [7:0] prod, input int bub_len);
        for (int k = 0; k < 4; k++) begin
            if (k == 0) begin
                b2 = b; g2 = g;
            end else begin
                b2 = 8'($urandom); g2 = 8'($urandom);
            end
            acc2 = (k == 3) ? acc : 8'($urandom);
            if (k == 3) q2.push_back('{p: prod ^ (MAC ? acc : 8'h00), due: cyc + 1});
            ctr2 = (k == 0);
            vld2 = 1'b1;
            a2   = 2'(a >> (6 - 2 * k));
            @(posedge clk); #1;
            if (k == 1) begin
                repeat (bub_len) begin
                    vld2 = 1'b0;
                    ctr2 = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end
        end
        vld2 = 1'b0;
        ctr2 = 1'b0;
    endtask

    initial begin
        logic [7:0] ra, rb, rg, racc;
        ctr1 = 0; vld1 = 0; a1 = 0; b1 = 0; g1 = 0; acc1 = 0;
        ctr2 = 0; vld2 = 0; a2 = 0; b2 = 0; g2 = 0; acc2 = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk); #1;

        // Reference vectors, D=1 and D=2
        op1(8'h57, 8'h83, 8'h1B, 8'h00, 8'hC1, 8, 0, 0);
        op2(8'h57, 8'h83, 8'h1B, 8'h00, 8'hC1, 0);
        repeat (2) @(posedge clk); #1;

        // Three bubbles after digit 4
        op1(8'h57, 8'h83, 8'h1B, 8'h00, 8'hC1, 8, 4, 3);
        repeat (2) @(posedge clk); #1;

        // Abort on digit 5 with a new operation
        op1(8'h57, 8'h83, 8'h1B, 8'h00, 8'h00, 4, 0, 0);
        err_exp1++;
        op1(8'h02, 8'h87, 8'h1B, 8'h00, 8'h15, 8, 0, 0);
        repeat (3) @(posedge clk); #1;
        check("err1_after_abort", err_seen1, err_exp1);

        // Reset during digit 5, then a fresh operation
        op1(8'h57, 8'h83, 8'h1B, 8'h00, 8'h00, 4, 0, 0);
        rst = 1'b0; vld1 = 1'b1; ctr1 = 1'b0; a1 = 1'b1;
        @(posedge clk); #1;
        vld1 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        op1(8'h57, 8'h83, 8'h1B, 8'h00, 8'hC1, 8, 0, 0);
        repeat (2) @(posedge clk); #1;

        // Stray digit while idle
        vld1 = 1'b1; ctr1 = 1'b0; a1 = 1'b1;
        @(posedge clk); #1;
        vld1 = 1'b0;
        err_exp1++;
        repeat (3) @(posedge clk); #1;
        check("err1_after_idle_digit", err_seen1, err_exp1);

`ifdef GF_PE_MAC_EN
        op1(8'h57, 8'h83, 8'h1B, 8'hFF, 8'hC1, 8, 0, 0);
        repeat (2) @(posedge clk); #1;
`endif

        // Random back-to-back operations with bubbles
        for (int t = 0; t < 6; t++) begin
            ra = 8'($urandom); rb = 8'($urandom); rg = 8'($urandom); racc = 8'($urandom);
            op1(ra, rb, rg, racc, gfmul(ra, rb, rg), 8, $urandom_range(0, 7), $urandom_range(0, 2));
        end
        for (int t = 0; t < 6; t++) begin
            ra = 8'($urandom); rb = 8'($urandom); rg = 8'($urandom); racc = 8'($urandom);
            op2(ra, rb, rg, racc, gfmul(ra, rb, rg), $urandom_range(0, 2));
        end

        repeat (5) @(posedge clk); #1;
        check("q1_drained", q1.size(), 0);
        check("q2_drained", q2.size(), 0);
        check("err1_total", err_seen1, err_exp1);
        check("err2_total", err_seen2, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
